// File: rtl/cla_pg_stage_if.sv
// Operand/result bundle for the CLA propagate/generate stage.
// master drives operands and out_ready; slave is the stage itself.
interface cla_pg_stage_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   cin;
    logic                   sub;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       p;
    logic [WIDTH-1:0]       g;
    logic                   c0;
    logic [WIDTH/2-1:0]     grp_p;
    logic [WIDTH/2-1:0]     grp_g;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, p, g, c0, grp_p, grp_g
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, p, g, c0, grp_p, grp_g
    );
endinterface

// File: rtl/cla_pg_stage.sv
// Propagate/generate front stage of a carry-lookahead adder/subtractor.
// Results are buffered in a 2-entry FIFO; outputs come only from the head entry.
module cla_pg_stage #(
    parameter int WIDTH = 16,
    parameter int GROUP = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_pg_stage_if.slave  bus
);
    localparam int NGRP = WIDTH / GROUP;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic             c0;
        logic [NGRP-1:0]  grp_p;
        logic [NGRP-1:0]  grp_g;
    } beat_t;

    beat_t            mem_q [2];
    beat_t            mem_d [2];
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_new, g_new;
    logic [NGRP-1:0]  grp_p_new, grp_g_new;
    logic             out_valid;
    logic             accept, consume;
    beat_t            head;

    always_comb begin
        b_eff = bus.sub ? ~bus.b : bus.b;
        p_new = bus.a ^ b_eff;
        g_new = bus.a & b_eff;
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        assign grp_p_new[k] = p_new[2*k+1] & p_new[2*k];
        assign grp_g_new[k] = g_new[2*k+1] | (p_new[2*k+1] & g_new[2*k]);
    end

    assign out_valid = (cnt_q != 2'd0);
    assign accept    = bus.in_valid & in_ready_q;
    assign consume   = out_valid & bus.out_ready;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ consume;
        mem_d    = mem_q;
        case ({accept, consume})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (accept) begin
            mem_d[wr_ptr_q] = '{p: p_new, g: g_new, c0: bus.cin | bus.sub,
                                grp_p: grp_p_new, grp_g: grp_g_new};
        end
        // Registered ready looks at next occupancy so a full-edge consume reopens next cycle.
        in_ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.p         = head.p;
    assign bus.g         = head.g;
    assign bus.c0        = head.c0;
    assign bus.grp_p     = head.grp_p;
    assign bus.grp_g     = head.grp_g;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_cla_pg_stage.sv
// Bench for cla_pg_stage: random and directed beats checked against a queue-based
// arithmetic reference of the 2-entry buffered propagate/generate stage.
module tb_cla_pg_stage;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0]   p;
        logic [W-1:0]   g;
        logic           c0;
        logic [W/2-1:0] gp;
        logic [W/2-1:0] gg;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_pg_stage_if #(.WIDTH(W)) bus ();

    cla_pg_stage #(.WIDTH(W), .GROUP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t model_q[$];
    bit   rdy_m = 1'b0;
    bit   last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Group generate = carry out of the 2-bit slice sum; group propagate = slice sum is all ones.
    function automatic ent_t ref_beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic ci, input logic sb);
        ent_t         e;
        logic [W-1:0] be;
        int           as, bs;
        be   = sb ? ~bv : bv;
        e.p  = av ^ be;
        e.g  = av & be;
        e.c0 = ci | sb;
        for (int k = 0; k < W/2; k++) begin
            as = int'((av >> (2*k)) & 16'd3);
            bs = int'((be >> (2*k)) & 16'd3);
            e.gg[k] = (as + bs) > 3;
            e.gp[k] = (as + bs) == 3;
        end
        return e;
    endfunction

    task automatic cycle(input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit ci, input bit sb, input bit ordy);
        bit acc, cons;
        bus.in_valid  = iv;
        bus.a         = av;
        bus.b         = bv;
        bus.cin       = ci;
        bus.sub       = sb;
        bus.out_ready = ordy;
        check("in_ready", bus.in_ready, rdy_m);
        check("out_valid", bus.out_valid, model_q.size() != 0);
        if (model_q.size() != 0) begin
            check("p", bus.p, model_q[0].p);
            check("g", bus.g, model_q[0].g);
            check("c0", bus.c0, model_q[0].c0);
            check("grp_p", bus.grp_p, model_q[0].gp);
            check("grp_g", bus.grp_g, model_q[0].gg);
        end
        acc  = iv && rdy_m;
        cons = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (cons) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_beat(av, bv, ci, sb));
        rdy_m    = model_q.size() < 2;
        last_acc = acc;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ha, hb;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_p", bus.p, 0);
        check("rst_g", bus.g, 0);
        check("rst_c0", bus.c0, 0);
        check("rst_grp", {bus.grp_p, bus.grp_g}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_m = 1'b0;
        idle(2);

        // Directed add
        cycle(1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        check("add_valid", bus.out_valid, 1);
        check("add_p", bus.p, 16'h0FF0);
        check("add_g", bus.g, 16'h000F);
        check("add_c0", bus.c0, 0);
        check("add_grp_g0", bus.grp_g[0], 1);
        check("add_grp_p0", bus.grp_p[0], 0);
        idle(1);

        // Directed subtract
        cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1);
        check("sub_p", bus.p, 16'hFFF9);
        check("sub_g", bus.g, 16'h0004);
        check("sub_c0", bus.c0, 1);
        idle(1);

        // Backpressure: three beats against a stalled sink, third held upstream
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        ha = 16'($urandom);
        hb = 16'($urandom);
        cycle(1'b1, ha, hb, 1'b1, 1'b0, 1'b0);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_depth", model_q.size(), 2);
        last_acc = 1'b0;
        for (int i = 0; i < 4 && !last_acc; i++) cycle(1'b1, ha, hb, 1'b1, 1'b0, 1'b1);
        check("bp_third_taken", last_acc, 1);
        idle(3);

        // Simultaneous accept/consume at one and at two entries
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1);
        check("sim1_depth", model_q.size(), 1);
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1);
        check("sim2_depth", model_q.size(), 1);
        idle(3);

        // Streaming
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        idle(2);

        // Random handshakes
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        idle(3);

        // Reset while full
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0);
        check("mr_depth", model_q.size(), 2);
        #1 rst_n = 1'b0;
        #1;
        check("mr_out_valid", bus.out_valid, 0);
        check("mr_in_ready", bus.in_ready, 0);
        check("mr_p", bus.p, 0);
        model_q.delete();
        rdy_m = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cla_pg_stage.md
CLA_PG_STAGE -- requirements
Module: cla_pg_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving operand width; the value SHALL be even and at least 2.
REQ-002 The block SHALL have parameter GROUP, fixed at 2, giving the bit-group size of the downstream carry base.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  the operand beat on a/b/cin/sub is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle; registered.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  1 = compute A-B; 0 = compute A+B.
REQ-011 out_valid  output  1  a p/g beat is presented.
REQ-012 out_ready  input  1  downstream consumes the beat this cycle.
REQ-013 p  output  WIDTH  per-bit propagate / half-sum, a ^ b_eff.
REQ-014 g  output  WIDTH  per-bit generate, a & b_eff.
REQ-015 c0  output  1  effective carry-in to the carry network.
REQ-016 grp_p  output  WIDTH/2  2-bit group propagate, p[2k+1] & p[2k].
REQ-017 grp_g  output  WIDTH/2  2-bit group generate, g[2k+1] | (p[2k+1] & g[2k]).

Function
REQ-018 b_eff SHALL be ~b and c0 SHALL be cin | sub when sub=1, and b_eff SHALL be b and c0 SHALL be cin when sub=0. For sub=1 with cin=0, this gives A + ~B + 1.
REQ-019 p, g, grp_p and grp_g SHALL be computed from a and b_eff at acceptance and stored in a 2-entry FIFO; the outputs SHALL be driven only from the FIFO head register.
REQ-020 A beat SHALL be accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-021 A beat SHALL be consumed when out_valid=1 and out_ready=1 on a rising edge.
REQ-022 Latency SHALL be 1 cycle: a beat accepted into an empty FIFO appears with out_valid=1 in the following cycle.
REQ-023 A 2-bit occupancy counter cnt in the range 0..2 SHALL track entries.
  - Accept-only: cnt+1.
  - Consume-only: cnt-1.
  - Both on the same edge: cnt unchanged.
REQ-024 out_valid SHALL equal (cnt != 0).
REQ-025 in_ready SHALL be a register, set to 1 when next cnt < 2 and cleared to 0 when next cnt = 2.
REQ-026 When full (cnt=2), a simultaneous consume SHALL make in_ready=1 on the next cycle; no beat SHALL be accepted on the full edge itself.
REQ-027 When cnt=1 with simultaneous accept and consume, the new beat SHALL become the head on the next cycle with no bubble.
REQ-028 Write and read pointers SHALL each be 1 bit and SHALL wrap 1 to 0.
REQ-029 Beats SHALL leave in acceptance order.
REQ-030 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 in_valid while in_ready=0 SHALL have no effect; the upstream holds the beat.
REQ-032 Arithmetic SHALL be bitwise only, with no overflow or carry-out computed here; the carry chain belongs to the downstream carry base.

Reset
REQ-033 While rst_n=0, the block SHALL hold the following asynchronously: cnt=0, both pointers=0, out_valid=0, in_ready=0, and p, g, c0, grp_p, grp_g all 0.
REQ-034 in_ready SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-operation SHALL discard all stored beats, with no beat emitted afterwards.

Verification
REQ-036 Add, WIDTH=16: a=0x00FF, b=0x0F0F, cin=0, sub=0 -> next cycle p=0x0FF0, g=0x000F, c0=0, grp_g[0]=1, grp_p[0]=0, out_valid=1.
REQ-037 Subtract: a=0x0005, b=0x0003, sub=1, cin=0 -> b_eff=0xFFFC, p=0xFFF9, g=0x0004, c0=1.
REQ-038 Backpressure: out_ready=0 with 3 consecutive valid beats.
  - Expected: in_ready=0 after 2 accepts; 3rd beat held upstream.
  - Expected: out_ready=1 yields beats 1, 2, 3 in order, with no loss or duplication.
REQ-039 Streaming: in_valid=1 and out_ready=1 continuously for 100 beats with random operands -> one beat out per cycle after the first; every output matches the reference model p=a^b_eff, g=a&b_eff.
REQ-040 Reset mid-stream: rst_n pulsed low while cnt=2 -> out_valid=0 immediately (asynchronous); after release, in_ready=1 one edge later and the old beats never appear.
REQ-041 Simultaneous accept and consume at cnt=1 and at cnt=2 -> cnt stays 1 in the first case and goes 2->1 in the second; ordering is preserved.
